// File: rtl/divider.sv
// Restoring unsigned divider: one quotient bit per clock, START/BUSY/DONE handshake.
// Latency WIDTH+1 cycles (1 for divide-by-zero); START is ignored while BUSY.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_BY_ZERO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   cand;
    logic             step_ok;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] shreg_nxt;

    assign accept    = (state != CALC) && START;
    assign last_step = (state == CALC) && (cnt == CW'(1));

    // shreg feeds dividend bits out of its MSB while quotient bits enter its LSB,
    // so after WIDTH steps it holds the full quotient.
    always_comb begin
        cand      = {prem, shreg[WIDTH-1]};
        step_ok   = (cand >= {1'b0, dvsr});
        prem_nxt  = step_ok ? (cand[WIDTH-1:0] - dvsr) : cand[WIDTH-1:0];
        shreg_nxt = {shreg[WIDTH-2:0], step_ok};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = (DIVISOR == '0) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                if (START) begin
                    state_nxt = (DIVISOR == '0) ? FINISH : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prem        <= '0;
            shreg       <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else if (accept) begin
            dvsr <= DIVISOR;
            if (DIVISOR != '0) begin
                prem  <= '0;
                shreg <= DIVIDEND;
                cnt   <= CW'(WIDTH);
            end else begin
                QUOTIENT    <= '1;
                REMAINDER   <= DIVIDEND;
                DIV_BY_ZERO <= 1'b1;
            end
        end else if (state == CALC) begin
            prem  <= prem_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt - CW'(1);
            if (last_step) begin
                QUOTIENT    <= shreg_nxt;
                REMAINDER   <= prem_nxt;
                DIV_BY_ZERO <= 1'b0;
            end
        end
    end

    // Pure decodes of the state flop: no combinational path from any input.
    assign BUSY = (state == CALC);
    assign DONE = (state == FINISH);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed table, back-to-back, reset abort, random sweep.
module tb_divider;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] DIVIDEND;
    logic [7:0] DIVISOR;
    logic [7:0] QUOTIENT;
    logic [7:0] REMAINDER;
    logic       BUSY;
    logic       DONE;
    logic       DIV_BY_ZERO;

    int n_cmp  = 0;
    int n_fail = 0;

    divider #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .DIVIDEND   (DIVIDEND),
        .DIVISOR    (DIVISOR),
        .QUOTIENT   (QUOTIENT),
        .REMAINDER  (REMAINDER),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for DONE; optionally pulse a stray START mid-flight.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inject,
                          output int lat, output int busy, output bit hold_ok);
        logic [7:0] q0, r0;
        logic       dz0;
        q0 = QUOTIENT; r0 = REMAINDER; dz0 = DIV_BY_ZERO;
        DIVIDEND = a; DIVISOR = b; START = 1'b1;
        lat = 0; busy = 0; hold_ok = 1'b1;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            START    = 1'b0;
            DIVIDEND = 8'($urandom);
            DIVISOR  = 8'($urandom);
            if (BUSY) begin
                busy++;
                if (QUOTIENT !== q0 || REMAINDER !== r0 || DIV_BY_ZERO !== dz0) hold_ok = 1'b0;
            end
            if (DONE) break;
            if (lat == inject) begin
                START = 1'b1; DIVIDEND = 8'd9; DIVISOR = 8'd3;
            end
        end
        START = 1'b0;
    endtask

    // Golden model: plain integer division, all-ones quotient for a zero divisor.
    task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b, input int inject);
        int          lat, busy;
        bit          hold_ok;
        logic [31:0] eq, er, prod;
        run_op(a, b, inject, lat, busy, hold_ok);
        eq = (b == 0) ? 32'd255 : 32'(a) / 32'(b);
        er = (b == 0) ? 32'(a)  : 32'(a) % 32'(b);
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
        chk({tag, "_busy_cycles"}, busy, (b == 0) ? 0 : 8);
        chk({tag, "_hold_during_calc"}, 32'(hold_ok), 1);
        chk({tag, "_quotient"}, QUOTIENT, eq);
        chk({tag, "_remainder"}, REMAINDER, er);
        chk({tag, "_div_by_zero"}, DIV_BY_ZERO, (b == 0) ? 1 : 0);
        if (b != 0) begin
            prod = 32'(QUOTIENT) * 32'(b) + 32'(REMAINDER);
            chk({tag, "_invariant"}, prod, 32'(a));
            chk({tag, "_rem_lt_div"}, 32'(REMAINDER < b), 1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[7];
        int   lat, busy;
        bit   hold_ok;

        vt[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
        vt[1] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, dz: 1'b1};
        vt[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
        vt[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
        vt[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
        vt[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
        vt[6] = '{a: 8'd200, b: 8'd128, q: 8'd1,   r: 8'd72, dz: 1'b0};

        RESET = 1'b0; START = 1'b0; DIVIDEND = '0; DIVISOR = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_quotient", QUOTIENT, 0);
        chk("reset_remainder", REMAINDER, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_dbz", DIV_BY_ZERO, 0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, 0, lat, busy, hold_ok);
            chk($sformatf("vec%0d_latency", i), lat, (vt[i].b == 0) ? 1 : 9);
            chk($sformatf("vec%0d_busy_cycles", i), busy, (vt[i].b == 0) ? 0 : 8);
            chk($sformatf("vec%0d_quotient", i), QUOTIENT, vt[i].q);
            chk($sformatf("vec%0d_remainder", i), REMAINDER, vt[i].r);
            chk($sformatf("vec%0d_div_by_zero", i), DIV_BY_ZERO, vt[i].dz);
            @(posedge CLK); #1;
            chk($sformatf("vec%0d_done_pulse_ends", i), DONE, 0);
            chk($sformatf("vec%0d_idle_not_busy", i), BUSY, 0);
            chk($sformatf("vec%0d_quotient_holds", i), QUOTIENT, vt[i].q);
            chk($sformatf("vec%0d_remainder_holds", i), REMAINDER, vt[i].r);
        end

        // Stray START mid-CALC is ignored; START on the DONE cycle chains with no idle gap.
        check_op("b2b_first", 8'd60, 8'd4, 3);
        check_op("b2b_second", 8'd9, 8'd3, 0);
        @(posedge CLK); #1;

        // Reset in the 4th CALC cycle aborts the operation.
        DIVIDEND = 8'd200; DIVISOR = 8'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("abort_busy_before_reset", BUSY, 1);
        RESET = 1'b0;
        #1;
        chk("abort_quotient", QUOTIENT, 0);
        chk("abort_remainder", REMAINDER, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_dbz", DIV_BY_ZERO, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk("abort_no_done", DONE, 0);
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_op("after_reset", 8'd10, 8'd3, 0);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] a, b;
            int         inj;
            a   = 8'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0;
            check_op("rand", a, b, inj);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
                chk("rand_done_pulse_ends", DONE, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Sequential unsigned integer divider for the ALU, complementing the combinational 8-bit multiplier. Computes QUOTIENT = DIVIDEND / DIVISOR and REMAINDER = DIVIDEND % DIVISOR by restoring division, one quotient bit per clock. A START/BUSY/DONE handshake lets the control unit stall the CPU while a division is in flight.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits; WIDTH >= 2.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
START  input  1  request a division; sampled only when not BUSY.
DIVIDEND  input  WIDTH  unsigned dividend; sampled in the START cycle.
DIVISOR  input  WIDTH  unsigned divisor; sampled in the START cycle.
QUOTIENT  output  WIDTH  registered quotient; valid from DONE until the next accepted START.
REMAINDER  output  WIDTH  registered remainder; same validity as QUOTIENT.
BUSY  output  1  high while a division is in progress (CALC state).
DONE  output  1  one-cycle pulse: result just became valid.
DIV_BY_ZERO  output  1  registered flag: last accepted operation had DIVISOR == 0; valid alongside QUOTIENT.

Behaviour:
- Reset (RESET = 0, asynchronous): state = IDLE. QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO and internal registers all 0. Reset mid-CALC aborts with no DONE.
- States: IDLE, CALC, FINISH.
- IDLE, or FINISH with START = 1: operands are latched.
  - DIVISOR != 0: partial remainder = 0, shift register = DIVIDEND, bit counter = WIDTH; go to CALC.
  - DIVISOR == 0: go to FINISH directly. On that edge load QUOTIENT = all ones, REMAINDER = DIVIDEND, DIV_BY_ZERO = 1.
- CALC, each cycle:
  - Form a (WIDTH+1)-bit trial = {partial remainder, MSB of shift register} minus {0, divisor}.
  - Trial non-negative: partial remainder = low WIDTH bits of trial, and 1 is shifted into the quotient LSB.
  - Otherwise: partial remainder = {partial remainder[WIDTH-2:0], shift MSB}, and 0 is shifted in.
  - Decrement the counter. When the counter reaches 1, go to FINISH and on that same edge update QUOTIENT, REMAINDER and DIV_BY_ZERO = 0.
- FINISH: DONE = 1 for exactly this one cycle. Without START, return to IDLE next edge. With START, the new operation is accepted (back-to-back).
- Latency: accepting edge to DONE-high edge is WIDTH+1 cycles for a non-zero divisor and 1 cycle for a zero divisor.
- BUSY = 1 exactly in CALC: WIDTH cycles per non-zero division; never high for divide-by-zero.
- START while BUSY is ignored. DIVIDEND and DIVISOR may change freely after the accepting edge.
- QUOTIENT, REMAINDER and DIV_BY_ZERO are updated only at the FINISH-entry edge. They hold their previous values throughout CALC.
- Arithmetic is unsigned. Invariant for DIVISOR != 0: QUOTIENT*DIVISOR + REMAINDER == DIVIDEND and REMAINDER < DIVISOR.
- BUSY and DONE are registered, with no combinational path from inputs.

Test Plan:
- Reset, then DIVIDEND = 100, DIVISOR = 7, START for 1 cycle -> BUSY high for 8 cycles, DONE pulses on the 9th edge, QUOTIENT = 14, REMAINDER = 2, DIV_BY_ZERO = 0; outputs hold after START deasserts.
- DIVIDEND = 37, DIVISOR = 0 -> DONE one edge after START, BUSY never high, QUOTIENT = 255, REMAINDER = 37, DIV_BY_ZERO = 1.
- Boundaries:
  - 255/1 -> Q = 255, R = 0.
  - 5/9 -> Q = 0, R = 5.
  - 0/3 -> Q = 0, R = 0.
  - 255/255 -> Q = 1, R = 0.
  - 200/128 -> Q = 1, R = 72.
- Issue 60/4, then pulse START with 9/3 mid-CALC (ignored); on the DONE cycle assert START with 9/3 -> first result Q = 15, R = 0. Second op accepted back-to-back with no IDLE cycle, yields Q = 3, R = 0.
- Start 200/3, pull RESET low on cycle 4 of CALC -> all outputs 0 immediately, no DONE. Release RESET, run 10/3 -> Q = 3, R = 1.
- Random sweep: 2000 random operand pairs including DIVISOR = 0 -> every result matches the golden model, and the invariant and latency rules hold.
